mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mips_pkg.sv | 42 ++++
 rtl/aludec.sv | 26 ++
 rtl/mc_controller.sv | 177 +++++++++++++++++
 tb/tb_mc_controller.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, funct codes,
// ALU operation codes and the FSM state encoding.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

endpackage

// File: rtl/aludec.sv
// Funct field to ALU operation decode for R-type instructions.
// Unknown funct codes fall back to ADD and raise bad_funct.
module aludec
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       bad_funct
);

    // pure table lookup, no state
    always_comb begin
        alu_control = ALU_ADD;
        bad_funct   = 1'b0;
        case (funct)
            FUNCT_ADD: alu_control = ALU_ADD;
            FUNCT_SUB: alu_control = ALU_SUB;
            FUNCT_AND: alu_control = ALU_AND;
            FUNCT_OR:  alu_control = ALU_OR;
            FUNCT_SLT: alu_control = ALU_SLT;
            FUNCT_SLL: alu_control = ALU_SLL;
            default:   bad_funct   = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM.
// Optional feature: define MC_BNE_EN to decode bne (Op 000101) as a branch
// taken on ~ZeroFlag; otherwise that opcode is reported as illegal.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | wait FETCH_WAIT cycles on imem, then load IR and PC+4
// DECODE    | compute branch target, dispatch on Op
// MEMADR    | base + signext offset for lw/sw
// MEMRD     | read data memory
// MEMWB     | write loaded data into rt
// MEMWR     | write rt to data memory
// RTYPEEX   | ALU op selected by Funct
// RTYPEWB   | write ALU result into rd
// BRANCH    | compare operands, load PC with target when taken
// ADDIEX    | rs + signext imm
// ADDIWB    | write sum into rt
// JUMP      | load PC with jump target
module mc_controller
    import mips_pkg::*;
#(
    parameter int FETCH_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       ZeroFlag,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [3:0] ALUControl,
    output logic       PCEn,
    output logic       Illegal
);

    localparam logic [2:0] WAIT_LAST = 3'(FETCH_WAIT);

    state_t     state, next_state;
    logic [2:0] wait_cnt;
    logic       fetch_last;
    logic [3:0] funct_alu;
    logic       bad_funct;

    aludec u_aludec (
        .funct       (Funct),
        .alu_control (funct_alu),
        .bad_funct   (bad_funct)
    );

    assign fetch_last = (wait_cnt == WAIT_LAST);

    // state register and FETCH wait counter; the counter only runs inside FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= 3'd0;
        end else begin
            state <= next_state;
            if (state == S_FETCH && !fetch_last)
                wait_cnt <= wait_cnt + 3'd1;
            else
                wait_cnt <= 3'd0;
        end
    end

    // next-state decode
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:   next_state = fetch_last ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTYPEEX;
                    OP_BEQ:       next_state = S_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:       next_state = S_BRANCH;
`endif
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  next_state = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   next_state = S_MEMWB;
            S_RTYPEEX: next_state = bad_funct ? S_FETCH : S_RTYPEWB;
            S_ADDIEX:  next_state = S_ADDIWB;
            default:   next_state = S_FETCH;
        endcase
    end

    // per-state outputs; IRWrite/PCEn are forced low while reset is held
    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUControl = 4'b0000;
        PCEn       = 1'b0;
        Illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                IRWrite    = fetch_last;
                PCEn       = fetch_last;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = ALU_ADD;
                case (Op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: Illegal = 1'b0;
`ifdef MC_BNE_EN
                    OP_BNE:  Illegal = 1'b0;
`endif
                    default: Illegal = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
            end
            S_MEMRD:   IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_RTYPEEX: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu;
                Illegal    = bad_funct;
            end
            S_RTYPEWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
`ifdef MC_BNE_EN
                PCEn       = (Op == OP_BNE) ? ~ZeroFlag : ZeroFlag;
`else
                PCEn       = ZeroFlag;
`endif
            end
            S_ADDIWB:  RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc = 2'b10;
                PCEn  = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            IRWrite = 1'b0;
            PCEn    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
`timescale 1ns/1ps
module tb_mc_controller;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Funct;
    logic       ZeroFlag;

    logic       iord0, mw0, ir0, rd0, mtr0, rw0, sa0, pcen0, ill0;
    logic [1:0] sb0, pcs0;
    logic [3:0] alu0;
    logic       iord3, mw3, ir3, rd3, mtr3, rw3, sa3, pcen3, ill3;
    logic [1:0] sb3, pcs3;
    logic [3:0] alu3;

    logic [16:0] v0, v3;
    assign v0 = {iord0, mw0, ir0, rd0, mtr0, rw0, sa0, sb0, pcs0, alu0, pcen0, ill0};
    assign v3 = {iord3, mw3, ir3, rd3, mtr3, rw3, sa3, sb3, pcs3, alu3, pcen3, ill3};

    mc_controller #(.FETCH_WAIT(0)) u0 (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .ZeroFlag(ZeroFlag),
        .IorD(iord0), .MemWrite(mw0), .IRWrite(ir0), .RegDst(rd0), .MemtoReg(mtr0),
        .RegWrite(rw0), .ALUSrcA(sa0), .ALUSrcB(sb0), .PCSrc(pcs0),
        .ALUControl(alu0), .PCEn(pcen0), .Illegal(ill0)
    );

    mc_controller #(.FETCH_WAIT(3)) u3 (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .ZeroFlag(ZeroFlag),
        .IorD(iord3), .MemWrite(mw3), .IRWrite(ir3), .RegDst(rd3), .MemtoReg(mtr3),
        .RegWrite(rw3), .ALUSrcA(sa3), .ALUSrcB(sb3), .PCSrc(pcs3),
        .ALUControl(alu3), .PCEn(pcen3), .Illegal(ill3)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic [3:0] alu;
        logic       ill;
    } vec_t;

    vec_t        vecs[17];
    logic [16:0] sbq[$];

    logic [16:0] E_FETCH, E_FWAIT, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB;
    logic [16:0] E_MEMWR, E_RTYPEWB, E_ADDIWB, E_JUMP;

    function automatic logic [16:0] ov(logic iord, logic mw, logic ir, logic rd,
                                       logic mtr, logic rw, logic sa, logic [1:0] sb,
                                       logic [1:0] pcs, logic [3:0] alu, logic pcen,
                                       logic ill);
        return {iord, mw, ir, rd, mtr, rw, sa, sb, pcs, alu, pcen, ill};
    endfunction

    task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", name, got, exp);
        end
    endtask

    task automatic push_expected(input vec_t v);
        sbq.push_back(E_FETCH);
        case (v.op)
            OP_LW: begin
                sbq.push_back(E_DECODE); sbq.push_back(E_MEMADR);
                sbq.push_back(E_MEMRD);  sbq.push_back(E_MEMWB);
            end
            OP_SW: begin
                sbq.push_back(E_DECODE); sbq.push_back(E_MEMADR); sbq.push_back(E_MEMWR);
            end
            OP_RTYPE: begin
                sbq.push_back(E_DECODE);
                sbq.push_back(ov(0,0,0,0,0,0,1,2'b00,2'b00,v.alu,0,v.ill));
                if (!v.ill) sbq.push_back(E_RTYPEWB);
            end
            OP_BEQ: begin
                sbq.push_back(E_DECODE);
                sbq.push_back(ov(0,0,0,0,0,0,1,2'b00,2'b01,4'b0110,v.zero,0));
            end
`ifdef MC_BNE_EN
            OP_BNE: begin
                sbq.push_back(E_DECODE);
                sbq.push_back(ov(0,0,0,0,0,0,1,2'b00,2'b01,4'b0110,~v.zero,0));
            end
`endif
            OP_ADDI: begin
                sbq.push_back(E_DECODE); sbq.push_back(E_MEMADR); sbq.push_back(E_ADDIWB);
            end
            OP_J: begin
                sbq.push_back(E_DECODE); sbq.push_back(E_JUMP);
            end
            default: sbq.push_back(E_DECODE | 17'd1);
        endcase
    endtask

    // called at a negedge with u0 in FETCH; returns at a negedge with u0 in FETCH
    task automatic run_instr(input vec_t v);
        int step;
        logic [16:0] exp;
        Op = v.op; Funct = v.funct; ZeroFlag = v.zero;
        push_expected(v);
        step = 1;
        while (sbq.size() > 0) begin
            exp = sbq.pop_front();
            #1;
            check($sformatf("%s cyc%0d", v.name, step), v0, exp);
            step++;
            @(negedge clk);
        end
    endtask

    initial begin
        E_FETCH   = ov(0,0,1,0,0,0,0,2'b01,2'b00,4'b0010,1,0);
        E_FWAIT   = ov(0,0,0,0,0,0,0,2'b01,2'b00,4'b0010,0,0);
        E_DECODE  = ov(0,0,0,0,0,0,0,2'b11,2'b00,4'b0010,0,0);
        E_MEMADR  = ov(0,0,0,0,0,0,1,2'b10,2'b00,4'b0010,0,0);
        E_MEMRD   = ov(1,0,0,0,0,0,0,2'b00,2'b00,4'b0000,0,0);
        E_MEMWB   = ov(0,0,0,0,1,1,0,2'b00,2'b00,4'b0000,0,0);
        E_MEMWR   = ov(1,1,0,0,0,0,0,2'b00,2'b00,4'b0000,0,0);
        E_RTYPEWB = ov(0,0,0,1,0,1,0,2'b00,2'b00,4'b0000,0,0);
        E_ADDIWB  = ov(0,0,0,0,0,1,0,2'b00,2'b00,4'b0000,0,0);
        E_JUMP    = ov(0,0,0,0,0,0,0,2'b00,2'b10,4'b0000,1,0);

        vecs[0]  = '{"lw",        OP_LW,    6'b000000, 1'b0, 4'b0010, 1'b0};
        vecs[1]  = '{"sw",        OP_SW,    6'b000000, 1'b0, 4'b0010, 1'b0};
        vecs[2]  = '{"r_add",     OP_RTYPE, 6'b100000, 1'b0, 4'b0010, 1'b0};
        vecs[3]  = '{"r_sub",     OP_RTYPE, 6'b100010, 1'b0, 4'b0110, 1'b0};
        vecs[4]  = '{"r_and",     OP_RTYPE, 6'b100100, 1'b1, 4'b0000, 1'b0};
        vecs[5]  = '{"r_or",      OP_RTYPE, 6'b100101, 1'b0, 4'b0001, 1'b0};
        vecs[6]  = '{"r_slt",     OP_RTYPE, 6'b101010, 1'b0, 4'b0111, 1'b0};
        vecs[7]  = '{"r_sll",     OP_RTYPE, 6'b000000, 1'b0, 4'b1000, 1'b0};
        vecs[8]  = '{"r_badfn",   OP_RTYPE, 6'b111111, 1'b0, 4'b0010, 1'b1};
        vecs[9]  = '{"beq_taken", OP_BEQ,   6'b000000, 1'b1, 4'b0110, 1'b0};
        vecs[10] = '{"beq_not",   OP_BEQ,   6'b000000, 1'b0, 4'b0110, 1'b0};
        vecs[11] = '{"bne_z1",    OP_BNE,   6'b000000, 1'b1, 4'b0110, 1'b0};
        vecs[12] = '{"bne_z0",    OP_BNE,   6'b000000, 1'b0, 4'b0110, 1'b0};
        vecs[13] = '{"addi",      OP_ADDI,  6'b000000, 1'b0, 4'b0010, 1'b0};
        vecs[14] = '{"j",         OP_J,     6'b000000, 1'b0, 4'b0010, 1'b0};
        vecs[15] = '{"op_3f",     6'b111111,6'b000000, 1'b0, 4'b0010, 1'b1};
        vecs[16] = '{"op_15",     6'b010101,6'b100000, 1'b1, 4'b0010, 1'b1};

        Op = OP_LW; Funct = 6'd0; ZeroFlag = 1'b0;
        rst = 1'b1;
        #2;
        check("reset_u0", v0, E_FWAIT);
        check("reset_u3", v3, E_FWAIT);

        // FETCH_WAIT=3: four FETCH cycles, strobes only in the last
        @(negedge clk); rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check($sformatf("fw3 fetch%0d", i), v3, (i == 4) ? E_FETCH : E_FWAIT);
            @(negedge clk);
        end
        #1;
        check("fw3 decode", v3, E_DECODE);

        @(negedge clk); rst = 1'b1;
        #2;
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 17; i++) run_instr(vecs[i]);

        // reset asserted while sw is in MEMWR
        Op = OP_SW; Funct = 6'd0; ZeroFlag = 1'b0;
        #1; check("sw_rst fetch", v0, E_FETCH);
        @(negedge clk); #1; check("sw_rst decode", v0, E_DECODE);
        @(negedge clk); #1; check("sw_rst memadr", v0, E_MEMADR);
        @(negedge clk); #1; check("sw_rst memwr", v0, E_MEMWR);
        #1; rst = 1'b1;
        #1; check("sw_rst during", v0, E_FWAIT);
        @(negedge clk); rst = 1'b0;
        #1; check("sw_rst release", v0, E_FETCH);
        check("sw_rst release u3", v3, E_FWAIT);
        @(negedge clk); #1; check("sw_rst redecode", v0, E_DECODE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
